mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter and transaction sequencer placed in front of the single-port `mem` block. It accepts read and write requests from two independent requesters and serialises them onto the one `valid`/`ready` memory port. It returns read data and a one-cycle completion pulse to the owning requester. It shares the memory's `clk` and `res` and drives the memory's `addr`/`wdata`/`wr_rd`/`valid` inputs directly.

## Interface
- WIDTH, 8: data width; matches the memory.
- DEPTH, 256: memory depth.
- ADDR_WIDTH, $clog2(DEPTH): address width.

- clk  in  1  single clock; all logic on rising edge.
- res  in  1  synchronous, active-high reset.
- p0_valid  in  1  port 0 request; held high with fields stable until `p0_done`.
- p0_wr_rd  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_WIDTH  port 0 address.
- p0_wdata  in  WIDTH  port 0 write data.
- p0_done  out  1  one-cycle completion pulse to port 0.
- p0_rdata  out  WIDTH  port 0 read data; valid when `p0_done`=1 for a read.
- p1_valid, p1_wr_rd, p1_addr, p1_wdata, p1_done, p1_rdata: same as port 0, for port 1.
- m_valid  out  1  to memory `valid`.
- m_wr_rd  out  1  to memory `wr_rd`.
- m_addr  out  ADDR_WIDTH  to memory `addr`.
- m_wdata  out  WIDTH  to memory `wdata`.
- m_ready  in  1  from memory `ready`.
- m_rdata  in  WIDTH  from memory `rdata`.
- busy  out  1  high whenever state is not IDLE.
- gnt_id  out  1  port owning the current/last transaction.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- **IDLE**
  - No request: stay in IDLE, `m_valid`=0.
  - Exactly one `pN_valid` high: grant port N.
  - Both high: grant the port not equal to `last`, the 1-bit pointer of the last completed grant.
  - On a grant: latch the port's `wr_rd`, `addr` and `wdata` into `m_*`, set `m_valid`=1, set `gnt_id`=N, go to ISSUE.
- **ISSUE**
  - Memory samples the request this cycle.
  - Clear `m_valid`, go to WAIT.
  - `m_addr`/`m_wdata`/`m_wr_rd` hold their values.
- **WAIT**
  - Stay until `m_ready`=1, with no timeout.
  - On `m_ready`=1: pulse `pN_done`=1 on the next cycle. For reads only, load `pN_rdata` from `m_rdata`. Set `last`=N and go to RESP.
- **RESP**
  - `pN_done` is high for exactly this one cycle. Requests are ignored.
  - Return to IDLE.
  - The requester drops or changes `pN_valid` on the edge where it samples `done`.
- `pN_rdata` holds its value until the next read completion for that port; writes do not alter it.
- The non-granted port's `done` stays 0 and its `rdata` is unchanged.
- A request that deasserts before it is granted is dropped silently. Deassertion after grant is not allowed; the in-flight transaction completes regardless.

## Timing
- Reset (edge with `res`=1), whatever the current state:
  - State becomes IDLE.
  - `m_valid`, `m_wr_rd`, `m_addr`, `m_wdata`, `p0_done`, `p1_done`, `p0_rdata`, `p1_rdata`, `busy`, `gnt_id` all become 0.
  - `last` becomes 1, so port 0 wins the first tie.
  - An in-flight transaction is abandoned with no `done` pulse.
- Latency with the standard memory (`ready` one cycle after `valid`). Request high in cycle T while IDLE:
  - T+1: `m_valid`=1.
  - T+2: `m_ready`=1.
  - T+3: `pN_done`=1.
  - T+4: IDLE, earliest next grant decision.
  - Peak throughput is one transaction per 4 cycles.
- `busy`=1 from T+1 through T+3.
- `m_valid` is high for exactly one cycle per transaction.
- Both ports held continuously valid: grants alternate 0,1,0,1…
- Starvation bound: a waiting port is served within one other transaction.
- `m_ready` seen in ISSUE is ignored; only WAIT samples it.

## Test plan
- **Reset:** assert `res` mid-WAIT → next cycle all outputs 0, `busy`=0, no `done`. After release, both ports request simultaneously → port 0 granted first (`gnt_id`=0).
- **Single write then read, port 0:** write addr 0x10 data 0xA5 → `p0_done` at T+3. Then read addr 0x10 → `p0_done` at T+3 with `p0_rdata`=0xA5. `p1_done` stays 0 throughout.
- **Contention:** both ports continuously valid for 8 transactions; p0 writes 0x11 @0x01, p1 writes 0x22 @0x02 → `gnt_id` sequence 0,1,0,1…, one `m_valid` pulse every 4 cycles.
- **Cross-port coherence:** p1 writes 0x3C @0xFF (top address), then p0 reads 0xFF → `p0_rdata`=0x3C; `p1_rdata` unchanged.
- **Stalled ready:** model holds `m_ready`=0 for 5 extra cycles → state stays WAIT, `busy`=1, `m_valid`=0, no `done`. Completion follows 1 cycle after `m_ready` rises.
- **Late arrival:** p1 raises valid while p0's transaction is in WAIT → p1 granted in the first IDLE cycle after RESP, `gnt_id`=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory-side and status signals of the two-port memory arbiter
//   p0_*/p1_* : requester ports (valid/wr_rd/addr/wdata in, done/rdata out)
//   m_*       : single-port memory bus (valid/wr_rd/addr/wdata out, ready/rdata in)
//   busy      : arbiter not idle; gnt_id: port owning current/last transaction
//   slave     : arbiter view; master: requester and memory view
interface mem_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic p0_valid, p0_wr_rd, p0_done;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [WIDTH-1:0] p0_wdata, p0_rdata;
  logic p1_valid, p1_wr_rd, p1_done;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [WIDTH-1:0] p1_wdata, p1_rdata;
  logic m_valid, m_wr_rd, m_ready;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [WIDTH-1:0] m_wdata, m_rdata;
  logic busy, gnt_id;
  modport slave (
    input p0_valid, p0_wr_rd, p0_addr, p0_wdata,
    input p1_valid, p1_wr_rd, p1_addr, p1_wdata,
    input m_ready, m_rdata,
    output p0_done, p0_rdata, p1_done, p1_rdata,
    output m_valid, m_wr_rd, m_addr, m_wdata, busy, gnt_id
  );
  modport master (
    output p0_valid, p0_wr_rd, p0_addr, p0_wdata,
    output p1_valid, p1_wr_rd, p1_addr, p1_wdata,
    output m_ready, m_rdata,
    input p0_done, p0_rdata, p1_done, p1_rdata,
    input m_valid, m_wr_rd, m_addr, m_wdata, busy, gnt_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter serialising requests onto one valid/ready memory port
//   clk, res : clock and synchronous active-high reset
//   bus      : slave side of mem_arbiter_if (requester ports, memory bus, busy, gnt_id)
module mem_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic clk,
  input logic res,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, gnt_q, gnt_d, busy_q, busy_d, pick;
  logic m_valid_q, m_valid_d, m_wr_rd_q, m_wr_rd_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0] m_wdata_q, m_wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0] done_q, done_d;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    gnt_d = gnt_q;
    m_valid_d = 1'b0;
    m_wr_rd_d = m_wr_rd_q;
    m_addr_d = m_addr_q;
    m_wdata_d = m_wdata_q;
    done_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // on a tie the port that did not complete last wins
    pick = (bus.p0_valid && bus.p1_valid) ? ~last_q : bus.p1_valid;
    case (state_q)
      IDLE: if (bus.p0_valid || bus.p1_valid) begin
        state_d = ISSUE;
        gnt_d = pick;
        m_valid_d = 1'b1;
        m_wr_rd_d = pick ? bus.p1_wr_rd : bus.p0_wr_rd;
        m_addr_d = pick ? bus.p1_addr : bus.p0_addr;
        m_wdata_d = pick ? bus.p1_wdata : bus.p0_wdata;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (bus.m_ready) begin
        state_d = RESP;
        last_d = gnt_q;
        done_d = gnt_q ? 2'b10 : 2'b01;
        rdata0_d = (!gnt_q && !m_wr_rd_q) ? bus.m_rdata : rdata0_q;
        rdata1_d = (gnt_q && !m_wr_rd_q) ? bus.m_rdata : rdata1_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      gnt_q <= 1'b0;
      busy_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_wr_rd_q <= 1'b0;
      m_addr_q <= '0;
      m_wdata_q <= '0;
      done_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      busy_q <= busy_d;
      m_valid_q <= m_valid_d;
      m_wr_rd_q <= m_wr_rd_d;
      m_addr_q <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      done_q <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign bus.m_valid = m_valid_q;
  assign bus.m_wr_rd = m_wr_rd_q;
  assign bus.m_addr = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.p0_done = done_q[0];
  assign bus.p1_done = done_q[1];
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;
  assign bus.busy = busy_q;
  assign bus.gnt_id = gnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int W = 8;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;
  mem_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();
  mem_arbiter #(.WIDTH(W), .DEPTH(256)) dut (.clk(clk), .res(res), .bus(bus.slave));
  logic [W-1:0] mem_m [256];
  logic pv [2];
  logic pw [2];
  logic [AW-1:0] pa [2];
  logic [W-1:0] pd [2];
  logic [W-1:0] exp_rd [2];
  logic last;
  int errs = 0;
  int checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive();
    bus.p0_valid = pv[0]; bus.p0_wr_rd = pw[0]; bus.p0_addr = pa[0]; bus.p0_wdata = pd[0];
    bus.p1_valid = pv[1]; bus.p1_wr_rd = pw[1]; bus.p1_addr = pa[1]; bus.p1_wdata = pd[1];
  endtask
  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    pv[p] = 1'b1; pw[p] = wr; pa[p] = a; pd[p] = d;
  endtask
  task automatic rand_req(input int p);
    set_req(p, 1'($urandom), ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)), W'($urandom));
  endtask
  task automatic chk_zero();
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_wr_rd", bus.m_wr_rd, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_done", {bus.p1_done, bus.p0_done}, 0);
    chk("rst_rdata", {bus.p1_rdata, bus.p0_rdata}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gnt", bus.gnt_id, 0);
  endtask
  // one arbitration opportunity starting in an IDLE cycle; the model predicts winner and timing
  task automatic round(input int stall, input bit spur, input bit late);
    int w;
    bit rd;
    drive();
    if (!pv[0] && !pv[1]) begin
      tick();
      chk("idle_m_valid", bus.m_valid, 0);
      chk("idle_busy", bus.busy, 0);
      return;
    end
    w = (pv[0] && pv[1]) ? int'(!last) : (pv[1] ? 1 : 0);
    rd = !pw[w];
    tick();
    chk("issue_m_valid", bus.m_valid, 1);
    chk("issue_busy", bus.busy, 1);
    chk("issue_gnt", bus.gnt_id, w);
    chk("issue_addr", bus.m_addr, pa[w]);
    chk("issue_wr_rd", bus.m_wr_rd, pw[w]);
    chk("issue_wdata", bus.m_wdata, pd[w]);
    chk("issue_done", {bus.p1_done, bus.p0_done}, 0);
    if (spur) begin
      bus.m_ready = 1'b1;
      bus.m_rdata = W'($urandom);
    end
    tick();
    bus.m_ready = 1'b0;
    chk("wait_m_valid", bus.m_valid, 0);
    chk("wait_busy", bus.busy, 1);
    chk("wait_done", {bus.p1_done, bus.p0_done}, 0);
    chk("wait_addr", bus.m_addr, pa[w]);
    if (late && !pv[1-w]) begin
      rand_req(1 - w);
      drive();
    end
    if (!rd) mem_m[pa[w]] = pd[w];
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_m_valid", bus.m_valid, 0);
      chk("stall_busy", bus.busy, 1);
      chk("stall_done", {bus.p1_done, bus.p0_done}, 0);
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = rd ? mem_m[pa[w]] : W'($urandom);
    tick();
    bus.m_ready = 1'b0;
    bus.m_rdata = W'($urandom);
    if (rd) exp_rd[w] = mem_m[pa[w]];
    chk("resp_done0", bus.p0_done, w == 0);
    chk("resp_done1", bus.p1_done, w == 1);
    chk("resp_rdata0", bus.p0_rdata, exp_rd[0]);
    chk("resp_rdata1", bus.p1_rdata, exp_rd[1]);
    chk("resp_busy", bus.busy, 1);
    chk("resp_gnt", bus.gnt_id, w);
    chk("resp_m_valid", bus.m_valid, 0);
    last = 1'(w);
    pv[w] = 1'b0;
    tick();
    chk("end_busy", bus.busy, 0);
    chk("end_done", {bus.p1_done, bus.p0_done}, 0);
  endtask
  initial begin
    res = 1'b1;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 1'b0; pw[p] = 1'b0; pa[p] = '0; pd[p] = '0; exp_rd[p] = '0;
    end
    last = 1'b1;
    drive();
    tick();
    tick();
    chk_zero();
    res = 1'b0;
    // single write then read on port 0
    set_req(0, 1'b1, 8'h10, 8'hA5);
    round(0, 1'b0, 1'b0);
    set_req(0, 1'b0, 8'h10, 8'h00);
    round(0, 1'b0, 1'b0);
    chk("p0_read_a5", bus.p0_rdata, 8'hA5);
    // continuous contention: grants must alternate
    for (int i = 0; i < 8; i++) begin
      if (!pv[0]) set_req(0, 1'b1, 8'h01, 8'h11);
      if (!pv[1]) set_req(1, 1'b1, 8'h02, 8'h22);
      round(0, 1'b0, 1'b0);
    end
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    // cross-port coherence at the top address
    set_req(1, 1'b1, 8'hFF, 8'h3C);
    round(0, 1'b0, 1'b0);
    set_req(0, 1'b0, 8'hFF, 8'h00);
    round(0, 1'b0, 1'b0);
    chk("p0_read_3c", bus.p0_rdata, 8'h3C);
    // stalled ready, with a stray ready during issue
    set_req(0, 1'b0, 8'h02, 8'h00);
    round(5, 1'b1, 1'b0);
    // late arrival of port 1 during port 0's wait
    set_req(0, 1'b1, 8'h20, 8'h5A);
    round(0, 1'b0, 1'b1);
    chk("late_pending", pv[1], 1);
    round(0, 1'b0, 1'b0);
    chk("late_gnt", bus.gnt_id, 1);
    // reset in the middle of a wait abandons the transaction
    set_req(0, 1'b1, 8'h30, 8'h77);
    drive();
    tick();
    tick();
    res = 1'b1;
    tick();
    chk_zero();
    res = 1'b0;
    last = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    set_req(0, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b0, 8'h02, 8'h00);
    round(0, 1'b0, 1'b0);
    chk("post_rst_tie", bus.gnt_id, 0);
    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) != 0) rand_req(p);
        else if (pv[p] && $urandom_range(0, 7) == 0) pv[p] = 1'b0;
      end
      round(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
